// File: rtl/vram_arbiter.sv
// vram_arbiter
// Shares the single framebuffer VRAM access port between two requesters.
// Port 0 (rasterizer) has priority. Port 1 (host/blitter) is starvation-bounded:
// after MAX_BURST consecutive port-0 grants while port 1 waits, port 1 wins.
// One transaction is outstanding at a time. The winner's request is registered
// toward VRAM and held until vram_ack_i. The bus always idles for one cycle
// between transactions.
//
// Ports:
//   clk, reset_n_i            pixel clock, async active-low reset
//   m{0,1}_sel/wr/mask/addr/data_i   requester request fields
//   m{0,1}_ack_o              completion pulse (combinational from vram_ack_i)
//   m{0,1}_data_o             read data (broadcast of vram_data_i)
//   vram_sel/wr/mask/addr/data_o     registered request to framebuffer
//   vram_ack_i, vram_data_i   framebuffer completion + read data
//   grant_o                   one-hot owner ({m1,m0}), 00 when idle
//   err_spurious_ack_o        sticky: ack seen while no transaction outstanding
module vram_arbiter #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n_i,
  input  logic                  m0_sel_i,
  input  logic                  m0_wr_i,
  input  logic [3:0]            m0_mask_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic                  m0_ack_o,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  input  logic                  m1_sel_i,
  input  logic                  m1_wr_i,
  input  logic [3:0]            m1_mask_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic                  m1_ack_o,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  vram_sel_o,
  output logic                  vram_wr_o,
  output logic [3:0]            vram_mask_o,
  output logic [ADDR_WIDTH-1:0] vram_addr_o,
  output logic [DATA_WIDTH-1:0] vram_data_o,
  input  logic                  vram_ack_i,
  input  logic [DATA_WIDTH-1:0] vram_data_i,
  output logic [1:0]            grant_o,
  output logic                  err_spurious_ack_o
);

  localparam int CW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic                  wr;
    logic [3:0]            mask;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  state_t        state, state_nxt;
  req_t          cur, m0_req, m1_req;
  logic [CW-1:0] burst_cnt, burst_cnt_nxt;
  logic          pick0, pick1, take, busy_ack;
  logic          sel_q, err_q;
  logic [1:0]    grant_q;

  assign m0_req = {m0_wr_i, m0_mask_i, m0_addr_i, m0_data_i};
  assign m1_req = {m1_wr_i, m1_mask_i, m1_addr_i, m1_data_i};

  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    // port 1 wins when port 0 is quiet or port 0 has used its burst allowance
    pick1 = m1_sel_i && (!m0_sel_i || burst_cnt == BURST_MAX);
    pick0 = m0_sel_i && !pick1;
    take  = (state == IDLE) && (pick0 || pick1);
    case (state)
      IDLE:    if (take)       state_nxt = BUSY;
      BUSY:    if (vram_ack_i) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
    // counter only measures how long port 1 has been kept waiting
    if (!m1_sel_i || (take && pick1))
      burst_cnt_nxt = '0;
    else if (take && pick0 && burst_cnt != BURST_MAX)
      burst_cnt_nxt = burst_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= IDLE;
      burst_cnt <= '0;
      cur       <= '0;
      sel_q     <= 1'b0;
      grant_q   <= 2'b00;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      if (take) begin
        cur     <= pick1 ? m1_req : m0_req;
        sel_q   <= 1'b1;
        grant_q <= {pick1, pick0};
      end else if (busy_ack) begin
        // address/data stay as last driven; only sel qualifies them
        sel_q   <= 1'b0;
        grant_q <= 2'b00;
      end
      // an ack with nothing outstanding (incl. one arriving after a reset
      // aborted a transaction) is dropped and flagged
      if (state == IDLE && vram_ack_i) err_q <= 1'b1;
    end
  end

  assign busy_ack = (state == BUSY) && vram_ack_i;

  assign vram_sel_o         = sel_q;
  assign vram_wr_o          = cur.wr;
  assign vram_mask_o        = cur.mask;
  assign vram_addr_o        = cur.addr;
  assign vram_data_o        = cur.data;
  assign grant_o            = grant_q;
  assign err_spurious_ack_o = err_q;

  assign m0_ack_o  = busy_ack && grant_q[0];
  assign m1_ack_o  = busy_ack && grant_q[1];
  assign m0_data_o = vram_data_i;
  assign m1_data_o = vram_data_i;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter (MAX_BURST=4).
// Requests are pushed to per-port scoreboard queues when driven; a VRAM
// responder captures each transaction and the test tasks pop and compare.
module tb_vram_arbiter;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset_n_i;
  logic          m0_sel_i, m0_wr_i, m1_sel_i, m1_wr_i;
  logic [3:0]    m0_mask_i, m1_mask_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [DW-1:0] m0_data_i, m1_data_i;
  logic          m0_ack_o, m1_ack_o;
  logic [DW-1:0] m0_data_o, m1_data_o;
  logic          vram_sel_o, vram_wr_o;
  logic [3:0]    vram_mask_o;
  logic [AW-1:0] vram_addr_o;
  logic [DW-1:0] vram_data_o;
  logic          vram_ack_i;
  logic [DW-1:0] vram_data_i;
  logic [1:0]    grant_o;
  logic          err_spurious_ack_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          wr;
    logic [3:0]    mask;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    bit            got;
    int            wait_cyc;
    bit            held;
    logic [1:0]    grant;
    logic          wr;
    logic [3:0]    mask;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack0, ack1;
    logic [DW-1:0] rd0, rd1;
  } obs_t;

  exp_t sb0[$];
  exp_t sb1[$];

  vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n_i(reset_n_i),
    .m0_sel_i(m0_sel_i), .m0_wr_i(m0_wr_i), .m0_mask_i(m0_mask_i),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
    .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
    .m1_sel_i(m1_sel_i), .m1_wr_i(m1_wr_i), .m1_mask_i(m1_mask_i),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
    .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
    .vram_sel_o(vram_sel_o), .vram_wr_o(vram_wr_o), .vram_mask_o(vram_mask_o),
    .vram_addr_o(vram_addr_o), .vram_data_o(vram_data_o),
    .vram_ack_i(vram_ack_i), .vram_data_i(vram_data_i),
    .grant_o(grant_o), .err_spurious_ack_o(err_spurious_ack_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // drive a request on port p and record what VRAM should later see
  task automatic req(input int p, input logic wr, input logic [3:0] mask,
                     input logic [AW-1:0] addr, input logic [DW-1:0] data);
    exp_t e;
    e.wr = wr; e.mask = mask; e.addr = addr; e.data = data;
    if (p == 0) begin
      m0_sel_i = 1'b1; m0_wr_i = wr; m0_mask_i = mask; m0_addr_i = addr; m0_data_i = data;
      sb0.push_back(e);
    end else begin
      m1_sel_i = 1'b1; m1_wr_i = wr; m1_mask_i = mask; m1_addr_i = addr; m1_data_i = data;
      sb1.push_back(e);
    end
  endtask

  // VRAM responder: wait (bounded) for vram_sel_o, watch it stay stable for
  // lat cycles, then raise ack in cycle M and capture the requester side.
  // Leaves vram_ack_i high; ack_end drops it in cycle M+1.
  task automatic serve(input int lat, input logic [DW-1:0] rdata, output obs_t o);
    o = '{default: 0};
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (vram_sel_o === 1'b1) begin o.got = 1; o.wait_cyc = i; break; end
    end
    if (!o.got) return;
    o.grant = grant_o; o.wr = vram_wr_o; o.mask = vram_mask_o;
    o.addr = vram_addr_o; o.wdata = vram_data_o; o.held = 1;
    repeat (lat) begin
      @(negedge clk);
      if (vram_sel_o !== 1'b1 || grant_o !== o.grant || vram_addr_o !== o.addr ||
          vram_wr_o !== o.wr || vram_mask_o !== o.mask || vram_data_o !== o.wdata)
        o.held = 0;
    end
    vram_data_i = rdata;
    vram_ack_i  = 1'b1;
    #1;
    o.ack0 = m0_ack_o; o.ack1 = m1_ack_o; o.rd0 = m0_data_o; o.rd1 = m1_data_o;
  endtask

  task automatic ack_end(output logic sel_after, output logic [1:0] g_after);
    @(negedge clk);
    vram_ack_i  = 1'b0;
    vram_data_i = '0;
    sel_after = vram_sel_o;
    g_after   = grant_o;
  endtask

  task automatic test_reset;
    reset_n_i = 1'b0;
    m0_sel_i = 0; m0_wr_i = 0; m0_mask_i = '0; m0_addr_i = '0; m0_data_i = '0;
    m1_sel_i = 0; m1_wr_i = 0; m1_mask_i = '0; m1_addr_i = '0; m1_data_i = '0;
    vram_ack_i = 0; vram_data_i = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o, vram_data_o} !== '0) begin
      errors++; $display("FAIL reset_vram got sel=%0b addr=%0h data=%0h want all 0", vram_sel_o, vram_addr_o, vram_data_o);
    end
    checks++;
    if (grant_o !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b want=00", grant_o); end
    checks++;
    if ({m0_ack_o, m1_ack_o, err_spurious_ack_o} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got ack0=%b ack1=%b err=%b want 0", m0_ack_o, m1_ack_o, err_spurious_ack_o);
    end
    reset_n_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_m0_write;
    obs_t o; exp_t e; logic sa; logic [1:0] ga;
    req(0, 1'b1, 4'hF, 24'h000100, 16'hABCD);
    serve(4, 16'h0000, o);
    m0_sel_i = 1'b0;
    ack_end(sa, ga);
    checks++;
    if (!o.got) begin errors++; $display("FAIL m0w_timeout vram_sel_o never rose"); return; end
    e = sb0.pop_front();
    checks++;
    if (o.wait_cyc !== 1) begin errors++; $display("FAIL m0w_latency got=%0d want=1", o.wait_cyc); end
    checks++;
    if (!o.held) begin errors++; $display("FAIL m0w_held vram request changed during cycles 1-5"); end
    checks++;
    if (o.grant !== 2'b01) begin errors++; $display("FAIL m0w_grant got=%b want=01", o.grant); end
    checks++;
    if ({o.wr, o.mask, o.addr, o.wdata} !== {e.wr, e.mask, e.addr, e.data}) begin
      errors++; $display("FAIL m0w_fields got wr=%b mask=%h addr=%h data=%h want wr=%b mask=%h addr=%h data=%h",
                         o.wr, o.mask, o.addr, o.wdata, e.wr, e.mask, e.addr, e.data);
    end
    checks++;
    if ({o.ack0, o.ack1} !== 2'b10) begin errors++; $display("FAIL m0w_ack got ack0=%b ack1=%b want 1,0", o.ack0, o.ack1); end
    checks++;
    if ({sa, ga} !== 3'b000) begin errors++; $display("FAIL m0w_after got sel=%b grant=%b want 0,00", sa, ga); end
  endtask

  task automatic test_m1_read;
    obs_t o; exp_t e; logic sa; logic [1:0] ga;
    req(1, 1'b0, 4'hF, 24'h012345, 16'h0000);
    serve(2, 16'h5A5A, o);
    m1_sel_i = 1'b0;
    ack_end(sa, ga);
    checks++;
    if (!o.got) begin errors++; $display("FAIL m1r_timeout vram_sel_o never rose"); return; end
    e = sb1.pop_front();
    checks++;
    if (o.grant !== 2'b10) begin errors++; $display("FAIL m1r_grant got=%b want=10", o.grant); end
    checks++;
    if ({o.wr, o.addr} !== {e.wr, e.addr}) begin
      errors++; $display("FAIL m1r_fields got wr=%b addr=%h want wr=%b addr=%h", o.wr, o.addr, e.wr, e.addr);
    end
    checks++;
    if ({o.ack1, o.rd1} !== {1'b1, 16'h5A5A}) begin
      errors++; $display("FAIL m1r_ack got ack1=%b data=%h want 1,5a5a", o.ack1, o.rd1);
    end
    checks++;
    if (o.ack0 !== 1'b0) begin errors++; $display("FAIL m1r_noack0 got ack0=%b want 0", o.ack0); end
    checks++;
    if (o.rd0 !== 16'h5A5A) begin errors++; $display("FAIL m1r_broadcast got m0_data=%h want 5a5a", o.rd0); end
    checks++;
    if ({sa, ga} !== 3'b000) begin errors++; $display("FAIL m1r_after got sel=%b grant=%b want 0,00", sa, ga); end
  endtask

  task automatic test_burst;
    obs_t o; exp_t e; logic sa; logic [1:0] ga;
    logic [1:0] order [10];
    int n0 = 0; int n1 = 0;
    order = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    req(0, 1'b1, 4'h3, 24'h001000, 16'h1000);
    req(1, 1'b1, 4'hC, 24'h002000, 16'h2000);
    for (int k = 0; k < 10; k++) begin
      serve(3, 16'h0000, o);
      checks++;
      if (!o.got) begin errors++; $display("FAIL burst_timeout txn=%0d", k); break; end
      e = (order[k] == 2'b01) ? sb0.pop_front() : sb1.pop_front();
      checks++;
      if (o.grant !== order[k]) begin errors++; $display("FAIL burst_grant txn=%0d got=%b want=%b", k, o.grant, order[k]); end
      checks++;
      if ({o.addr, o.wdata, o.mask} !== {e.addr, e.data, e.mask}) begin
        errors++; $display("FAIL burst_fields txn=%0d got addr=%h data=%h want addr=%h data=%h", k, o.addr, o.wdata, e.addr, e.data);
      end
      checks++;
      if ({o.ack1, o.ack0} !== order[k] || !o.held || o.wait_cyc !== 1) begin
        errors++; $display("FAIL burst_ack txn=%0d got acks=%b%b held=%0d wait=%0d want %b,1,1", k, o.ack1, o.ack0, o.held, o.wait_cyc, order[k]);
      end
      if (k == 9) begin
        m0_sel_i = 1'b0; m1_sel_i = 1'b0;
      end else if (order[k] == 2'b01) begin
        n0++; req(0, 1'b1, 4'h3, AW'(32'h1000 + n0), DW'(32'h1000 + n0));
      end else begin
        n1++; req(1, 1'b1, 4'hC, AW'(32'h2000 + n1), DW'(32'h2000 + n1));
      end
      ack_end(sa, ga);
      checks++;
      if ({sa, ga} !== 3'b000) begin errors++; $display("FAIL burst_gap txn=%0d got sel=%b grant=%b want 0,00", k, sa, ga); end
    end
    m0_sel_i = 1'b0; m1_sel_i = 1'b0;
    sb0.delete(); sb1.delete();
  endtask

  // 20 m0-only transactions must not advance the burst count: when m1 then
  // joins, m0 still gets MB more grants before m1 wins.
  task automatic test_m0_stream;
    obs_t o; exp_t e; logic sa; logic [1:0] ga; logic [1:0] eg;
    req(0, 1'b0, 4'h1, 24'h300000, 16'h0000);
    for (int k = 0; k < 20 + MB + 1; k++) begin
      eg = (k == 20 + MB) ? 2'b10 : 2'b01;
      serve(1, DW'(k), o);
      checks++;
      if (!o.got) begin errors++; $display("FAIL stream_timeout txn=%0d", k); break; end
      e = (eg == 2'b01) ? sb0.pop_front() : sb1.pop_front();
      checks++;
      if (o.grant !== eg || o.addr !== e.addr) begin
        errors++; $display("FAIL stream_grant txn=%0d got grant=%b addr=%h want grant=%b addr=%h", k, o.grant, o.addr, eg, e.addr);
      end
      checks++;
      if ({o.ack1, o.ack0} !== eg) begin errors++; $display("FAIL stream_ack txn=%0d got=%b%b want=%b", k, o.ack1, o.ack0, eg); end
      if (k == 19) req(1, 1'b0, 4'h2, 24'h400000, 16'h0000);
      if (k < 20 + MB) req(0, 1'b0, 4'h1, AW'(32'h300000 + k + 1), 16'h0000);
      else begin m0_sel_i = 1'b0; m1_sel_i = 1'b0; end
      ack_end(sa, ga);
    end
    m0_sel_i = 1'b0; m1_sel_i = 1'b0;
    sb0.delete(); sb1.delete();
  endtask

  task automatic test_spurious;
    obs_t o; logic sa; logic [1:0] ga;
    @(negedge clk);
    checks++;
    if (err_spurious_ack_o !== 1'b0) begin errors++; $display("FAIL spur_pre got err=%b want 0", err_spurious_ack_o); end
    vram_ack_i = 1'b1;
    #1;
    checks++;
    if ({m0_ack_o, m1_ack_o} !== 2'b00) begin errors++; $display("FAIL spur_route got ack0=%b ack1=%b want 0,0", m0_ack_o, m1_ack_o); end
    @(negedge clk);
    vram_ack_i = 1'b0;
    checks++;
    if ({err_spurious_ack_o, vram_sel_o, grant_o} !== 4'b1000) begin
      errors++; $display("FAIL spur_flag got err=%b sel=%b grant=%b want 1,0,00", err_spurious_ack_o, vram_sel_o, grant_o);
    end
    req(0, 1'b1, 4'h5, 24'h00ABCD, 16'h1234);
    serve(2, 16'h0000, o);
    m0_sel_i = 1'b0;
    ack_end(sa, ga);
    void'(sb0.pop_front());
    checks++;
    if ({o.got, o.ack0, err_spurious_ack_o} !== 3'b111) begin
      errors++; $display("FAIL spur_sticky got txn=%b ack0=%b err=%b want 1,1,1", o.got, o.ack0, err_spurious_ack_o);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);                          // cycle 0
    req(0, 1'b1, 4'hF, 24'h00BEEF, 16'hCAFE);
    repeat (3) @(negedge clk);               // cycle 3, BUSY
    checks++;
    if (vram_sel_o !== 1'b1) begin errors++; $display("FAIL rmid_busy got sel=%b want 1", vram_sel_o); end
    reset_n_i = 1'b0;
    m0_sel_i  = 1'b0;
    #1;
    checks++;
    if ({vram_sel_o, grant_o, vram_addr_o, vram_data_o, err_spurious_ack_o} !== '0) begin
      errors++; $display("FAIL rmid_async got sel=%b grant=%b addr=%h err=%b want all 0", vram_sel_o, grant_o, vram_addr_o, err_spurious_ack_o);
    end
    @(negedge clk);                          // cycle 4
    reset_n_i = 1'b1;
    repeat (2) @(negedge clk);               // cycle 6
    vram_ack_i = 1'b1;
    #1;
    checks++;
    if ({m0_ack_o, m1_ack_o, err_spurious_ack_o} !== 3'b000) begin
      errors++; $display("FAIL rmid_late_ack got ack0=%b ack1=%b err=%b want 0,0,0", m0_ack_o, m1_ack_o, err_spurious_ack_o);
    end
    @(negedge clk);                          // cycle 7
    vram_ack_i = 1'b0;
    checks++;
    if ({err_spurious_ack_o, vram_sel_o} !== 2'b10) begin
      errors++; $display("FAIL rmid_err got err=%b sel=%b want 1,0", err_spurious_ack_o, vram_sel_o);
    end
    sb0.delete();
  endtask

  initial begin
    test_reset();
    test_m0_write();
    test_m1_read();
    test_burst();
    test_m0_stream();
    test_spurious();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
